// File: rtl/video_pkg.sv
// Shared 720p video timing types and constants, used by the timing generator
// and the downstream sprite stages.
package video_pkg;

  typedef enum logic [1:0] {
    H_ACTIVE = 2'd0,
    H_FRONT  = 2'd1,
    H_SYNCP  = 2'd2,
    H_BACK   = 2'd3
  } h_phase_t;

  typedef enum logic [1:0] {
    V_ACTIVE = 2'd0,
    V_FRONT  = 2'd1,
    V_SYNCP  = 2'd2,
    V_BACK   = 2'd3
  } v_phase_t;

  localparam int VID_ACTIVE_H = 1280;
  localparam int VID_H_FP     = 110;
  localparam int VID_H_SYNC   = 40;
  localparam int VID_H_BP     = 220;
  localparam int VID_ACTIVE_V = 720;
  localparam int VID_V_FP     = 5;
  localparam int VID_V_SYNC   = 5;
  localparam int VID_V_BP     = 20;
  localparam int VID_H_TOTAL  = VID_ACTIVE_H + VID_H_FP + VID_H_SYNC + VID_H_BP;
  localparam int VID_V_TOTAL  = VID_ACTIVE_V + VID_V_FP + VID_V_SYNC + VID_V_BP;

endpackage

// File: rtl/video_timing_gen_sync_delay.sv
// sync_delay: fixed-depth shift register for a small flag bundle; depth 0
// is a straight wire.
module sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_s;
      assign unused_s = clk ^ rst;
      assign dout     = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_r [DEPTH];

      // shift chain, every stage cleared by reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
        end else begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with phase FSMs and delayed sync/active flags.
// Optional frame counter enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int ACTIVE_H = VID_ACTIVE_H,
  parameter int H_FP     = VID_H_FP,
  parameter int H_SYNC   = VID_H_SYNC,
  parameter int H_BP     = VID_H_BP,
  parameter int ACTIVE_V = VID_ACTIVE_V,
  parameter int V_FP     = VID_V_FP,
  parameter int V_SYNC   = VID_V_SYNC,
  parameter int V_BP     = VID_V_BP,
  parameter int DELAY    = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic        new_frame_out,
  output logic        hsync_dly_out,
  output logic        vsync_dly_out,
  output logic        active_draw_dly_out,
  output logic [5:0]  frame_count_out
);

  localparam int H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST        = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FRONT_START = 11'(ACTIVE_H);
  localparam logic [10:0] H_SYNC_START  = 11'(ACTIVE_H + H_FP);
  localparam logic [10:0] H_BACK_START  = 11'(ACTIVE_H + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST        = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_FRONT_START = 10'(ACTIVE_V);
  localparam logic [9:0]  V_SYNC_START  = 10'(ACTIVE_V + V_FP);
  localparam logic [9:0]  V_BACK_START  = 10'(ACTIVE_V + V_FP + V_SYNC);

  logic [10:0] h_cnt_r, h_next_s;
  logic [9:0]  v_cnt_r, v_next_s;
  logic        h_wrap_s;
  h_phase_t    h_state_r, h_state_s;
  v_phase_t    v_state_r, v_state_s;
  logic        hsync_r, vsync_r, active_r, new_frame_r;
  logic        new_frame_s;
  logic [2:0]  flags_dly_s;

  // next-state counters
  always_comb begin
    h_wrap_s = (h_cnt_r == H_LAST);
    if (h_wrap_s) h_next_s = 11'd0;
    else          h_next_s = h_cnt_r + 11'd1;
    if (!h_wrap_s)              v_next_s = v_cnt_r;
    else if (v_cnt_r == V_LAST) v_next_s = 10'd0;
    else                        v_next_s = v_cnt_r + 10'd1;
  end

  // horizontal phase next-state, tracking the phase of h_next_s
  always_comb begin
    h_state_s = h_state_r;
    case (h_state_r)
      H_ACTIVE: if (h_next_s == H_FRONT_START) h_state_s = H_FRONT;  else h_state_s = H_ACTIVE;
      H_FRONT:  if (h_next_s == H_SYNC_START)  h_state_s = H_SYNCP;  else h_state_s = H_FRONT;
      H_SYNCP:  if (h_next_s == H_BACK_START)  h_state_s = H_BACK;   else h_state_s = H_SYNCP;
      H_BACK:   if (h_wrap_s)                  h_state_s = H_ACTIVE; else h_state_s = H_BACK;
      default:  h_state_s = H_ACTIVE;
    endcase
  end

  // vertical phase next-state, only moves on the line wrap
  always_comb begin
    v_state_s = v_state_r;
    if (h_wrap_s) begin
      case (v_state_r)
        V_ACTIVE: if (v_next_s == V_FRONT_START) v_state_s = V_FRONT;  else v_state_s = V_ACTIVE;
        V_FRONT:  if (v_next_s == V_SYNC_START)  v_state_s = V_SYNCP;  else v_state_s = V_FRONT;
        V_SYNCP:  if (v_next_s == V_BACK_START)  v_state_s = V_BACK;   else v_state_s = V_SYNCP;
        V_BACK:   if (v_next_s == 10'd0)         v_state_s = V_ACTIVE; else v_state_s = V_BACK;
        default:  v_state_s = V_ACTIVE;
      endcase
    end else begin
      v_state_s = v_state_r;
    end
  end

  assign new_frame_s = (h_next_s == H_FRONT_START) && (v_next_s == V_FRONT_START);

  // counters, phase registers and flags, all decoded from next-state values
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      h_cnt_r     <= 11'd0;
      v_cnt_r     <= 10'd0;
      h_state_r   <= H_ACTIVE;
      v_state_r   <= V_ACTIVE;
      hsync_r     <= 1'b0;
      vsync_r     <= 1'b0;
      active_r    <= 1'b0;
      new_frame_r <= 1'b0;
    end else begin
      h_cnt_r     <= h_next_s;
      v_cnt_r     <= v_next_s;
      h_state_r   <= h_state_s;
      v_state_r   <= v_state_s;
      hsync_r     <= (h_state_s == H_SYNCP);
      vsync_r     <= (v_state_s == V_SYNCP);
      active_r    <= (h_state_s == H_ACTIVE) && (v_state_s == V_ACTIVE);
      new_frame_r <= new_frame_s;
    end
  end

  sync_delay #(
    .WIDTH (3),
    .DEPTH (DELAY)
  ) u_sync_delay (
    .clk  (pixel_clk_in),
    .rst  (rst_in),
    .din  ({hsync_r, vsync_r, active_r}),
    .dout (flags_dly_s)
  );

`ifdef VTG_FRAME_COUNT_EN
  logic [5:0] frame_cnt_r;

  // frame counter steps on the same edge that raises new_frame_out
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in)           frame_cnt_r <= 6'd0;
    else if (new_frame_s) frame_cnt_r <= frame_cnt_r + 6'd1;
    else                  frame_cnt_r <= frame_cnt_r;
  end

  assign frame_count_out = frame_cnt_r;
`else
  assign frame_count_out = 6'd0;
`endif

  assign hcount_out          = h_cnt_r;
  assign vcount_out          = v_cnt_r;
  assign hsync_out           = hsync_r;
  assign vsync_out           = vsync_r;
  assign active_draw_out     = active_r;
  assign new_frame_out       = new_frame_r;
  assign hsync_dly_out       = flags_dly_s[2];
  assign vsync_dly_out       = flags_dly_s[1];
  assign active_draw_dly_out = flags_dly_s[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced raster; expected
// values come from arithmetic on the number of edges since reset release.
module tb_video_timing_gen;

  localparam int AH = 16, HFP = 3, HS = 4, HBP = 5;
  localparam int AV = 10, VFP = 2, VS = 3, VBP = 4;
  localparam int DLY = 4;
  localparam int HT = AH + HFP + HS + HBP;
  localparam int VT = AV + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int NF_POS = AV * HT + AH;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, active_draw, new_frame;
  logic        hsync_dly, vsync_dly, active_draw_dly;
  logic [5:0]  frame_count;

  int k;
  int assert_cnt;
  int fail_cnt;

  video_timing_gen #(
    .ACTIVE_H (AH), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .ACTIVE_V (AV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .DELAY    (DLY)
  ) dut (
    .pixel_clk_in        (clk),
    .rst_in              (rst),
    .hcount_out          (hcount),
    .vcount_out          (vcount),
    .hsync_out           (hsync),
    .vsync_out           (vsync),
    .active_draw_out     (active_draw),
    .new_frame_out       (new_frame),
    .hsync_dly_out       (hsync_dly),
    .vsync_dly_out       (vsync_dly),
    .active_draw_dly_out (active_draw_dly),
    .frame_count_out     (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
    end
  endtask

  function automatic int exp_h(int kk);
    if (kk <= 0) return 0;
    return (kk % FRAME) % HT;
  endfunction

  function automatic int exp_v(int kk);
    if (kk <= 0) return 0;
    return (kk % FRAME) / HT;
  endfunction

  function automatic logic exp_hs(int kk);
    if (kk <= 0) return 1'b0;
    return (exp_h(kk) >= AH + HFP) && (exp_h(kk) < AH + HFP + HS);
  endfunction

  function automatic logic exp_vs(int kk);
    if (kk <= 0) return 1'b0;
    return (exp_v(kk) >= AV + VFP) && (exp_v(kk) < AV + VFP + VS);
  endfunction

  function automatic logic exp_ad(int kk);
    if (kk <= 0) return 1'b0;
    return (exp_h(kk) < AH) && (exp_v(kk) < AV);
  endfunction

  function automatic logic exp_nf(int kk);
    if (kk <= 0) return 1'b0;
    return (exp_h(kk) == AH) && (exp_v(kk) == AV);
  endfunction

  function automatic int exp_fc(int kk);
`ifdef VTG_FRAME_COUNT_EN
    if (kk < NF_POS) return 0;
    return (((kk - NF_POS) / FRAME) + 1) % 64;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs();
    check_val("hcount",   32'(hcount),          32'(exp_h(k)));
    check_val("vcount",   32'(vcount),          32'(exp_v(k)));
    check_val("hsync",    32'(hsync),           32'(exp_hs(k)));
    check_val("vsync",    32'(vsync),           32'(exp_vs(k)));
    check_val("active",   32'(active_draw),     32'(exp_ad(k)));
    check_val("newframe", 32'(new_frame),       32'(exp_nf(k)));
    check_val("hs_dly",   32'(hsync_dly),       32'(exp_hs(k - DLY)));
    check_val("vs_dly",   32'(vsync_dly),       32'(exp_vs(k - DLY)));
    check_val("ad_dly",   32'(active_draw_dly), 32'(exp_ad(k - DLY)));
    check_val("framecnt", 32'(frame_count),     32'(exp_fc(k)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) k++;
    @(negedge clk);
    check_outputs();
  endtask

  // asynchronous assert between edges, check zeros before the next edge
  task automatic async_reset(input int hold);
    @(negedge clk);
    #2;
    rst = 1'b1;
    k = 0;
    #1;
    check_outputs();
    for (int i = 0; i < hold; i++) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_val("rel_h", 32'(hcount), 32'd1);
    check_val("rel_v", 32'(vcount), 32'd0);
    check_val("rel_ad", 32'(active_draw), 32'd1);
  endtask

  initial begin
    int act_cnt, nf_cnt, hs_rise, vs_cycles, hs_run, last_rise_k;
    logic prev_hs, prev_hsd;
    assert_cnt = 0;
    fail_cnt = 0;
    k = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // first line after release
    act_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      tick();
      if (active_draw) act_cnt++;
    end
    check_val("line_h_wrap", 32'(hcount), 32'd0);
    check_val("line_v", 32'(vcount), 32'd1);
    check_val("line_active_cnt", 32'(act_cnt), 32'(AH));

    // one whole frame: pulse counts, sync widths and delayed-flag timing
    nf_cnt = 0; hs_rise = 0; vs_cycles = 0; hs_run = 0; last_rise_k = -100;
    prev_hs = hsync; prev_hsd = hsync_dly;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (new_frame) begin
        nf_cnt++;
        check_val("nf_h", 32'(hcount), 32'(AH));
        check_val("nf_v", 32'(vcount), 32'(AV));
      end
      if (vsync) vs_cycles++;
      if (hsync) hs_run++;
      if (hsync && !prev_hs) begin
        hs_rise++;
        last_rise_k = k;
      end
      if (!hsync && prev_hs) begin
        check_val("hs_width", 32'(hs_run), 32'(HS));
        hs_run = 0;
      end
      if (hsync_dly && !prev_hsd) check_val("hs_dly_lag", 32'(k - last_rise_k), 32'(DLY));
      if (k >= FRAME && exp_v(k) == 0 && exp_h(k) == 3) check_val("ad_dly_h3", 32'(active_draw_dly), 32'd0);
      if (k >= FRAME && exp_v(k) == 0 && exp_h(k) == 4) check_val("ad_dly_h4", 32'(active_draw_dly), 32'd1);
      prev_hs = hsync;
      prev_hsd = hsync_dly;
    end
    check_val("frame_nf_cnt", 32'(nf_cnt), 32'd1);
    check_val("frame_hs_cnt", 32'(hs_rise), 32'(VT));
    check_val("frame_vs_lines", 32'(vs_cycles / HT), 32'(VS));

    // mid-frame asynchronous reset at a fixed raster position
    for (int i = 0; i < FRAME && !(exp_h(k) == 10 && exp_v(k) == 5); i++) tick();
    check_val("pre_rst_h", 32'(hcount), 32'd10);
    async_reset(2);

    // randomized run lengths and reset hold times
    for (int r = 0; r < 6; r++) begin
      int run_len;
      run_len = int'($urandom_range(1, 600));
      for (int i = 0; i < run_len; i++) tick();
      async_reset(int'($urandom_range(0, 3)));
    end

    // 65 frames from a fresh release: frame counter wraps 63 -> 0 -> 1
    async_reset(1);
    for (int i = 0; i < 65 * FRAME; i++) tick();
    check_val("fc_final", 32'(frame_count), 32'(exp_fc(k)));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- ACTIVE_H, 1280, visible pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- ACTIVE_V, 720, visible lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- DELAY, 4, pipeline depth of the *_dly outputs; equals sprite-stage latency
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- pixel_clk_in, in, 1, pixel clock
- rst_in, in, 1, asynchronous active-high reset
- hcount_out, out, 11, horizontal position
- vcount_out, out, 10, vertical position
- hsync_out, out, 1, active-high hsync
- vsync_out, out, 1, active-high vsync
- active_draw_out, out, 1, pixel is in the visible region
- new_frame_out, out, 1, one-cycle start-of-blanking pulse
- hsync_dly_out, out, 1, hsync_out delayed DELAY cycles
- vsync_dly_out, out, 1, vsync_out delayed DELAY cycles
- active_draw_dly_out, out, 1, active_draw_out delayed DELAY cycles
- frame_count_out, out, 6, frame counter
REQ-003 SHALL use one clock, pixel_clk_in; rst_in SHALL be asynchronous and active-high.

Function
REQ-004 SHALL define H_TOTAL = ACTIVE_H+H_FP+H_SYNC+H_BP (1650) and V_TOTAL = ACTIVE_V+V_FP+V_SYNC+V_BP (750).
REQ-005 hcount_out SHALL increment by 1 every cycle and wrap from H_TOTAL-1 to 0.
REQ-006 vcount_out SHALL increment only on the hcount wrap, and SHALL itself wrap from V_TOTAL-1 to 0; both wraps occur on the same edge at frame end.
REQ-007 The horizontal phase FSM SHALL have states H_ACTIVE, H_FRONT, H_SYNCP, H_BACK, with transitions at hcount ACTIVE_H, ACTIVE_H+H_FP, ACTIVE_H+H_FP+H_SYNC, and the wrap to 0. The vertical FSM SHALL mirror this on vcount, advancing only at the hcount wrap.
REQ-008 All outputs SHALL be registered and mutually consistent within a cycle; flags SHALL be decoded from next-state counters.
REQ-009 hsync_out SHALL be 1 iff hcount_out is in [1390,1430).
REQ-010 vsync_out SHALL be 1 iff vcount_out is in [725,730).
REQ-011 active_draw_out SHALL be 1 iff hcount_out<ACTIVE_H and vcount_out<ACTIVE_V.
REQ-012 new_frame_out SHALL be 1 for exactly one cycle per frame, when hcount_out==ACTIVE_H and vcount_out==ACTIVE_V.
REQ-013 The *_dly outputs SHALL be exact DELAY-cycle shift-register copies; DELAY=0 SHALL make them equal to the undelayed outputs.
REQ-014 hcount_out and vcount_out SHALL NOT be delayed; the downstream sprite stage delays them internally.

Reset
REQ-015 While rst_in=1, every output SHALL be 0, including all delay stages and the FSMs (H_ACTIVE/V_ACTIVE).
REQ-016 The first rising edge after release SHALL produce hcount=1, vcount=0, active_draw_out=1. Reset asserted mid-frame SHALL take effect immediately, with no completion of the line.

Configuration
REQ-017 With VTG_FRAME_COUNT_EN defined, frame_count_out SHALL increment on the edge where new_frame_out rises, wrapping 63->0.
REQ-018 Without VTG_FRAME_COUNT_EN, frame_count_out SHALL be constant 0 and no counter register SHALL be inferred.

Structure
REQ-019 Package video_pkg SHALL hold the h/v phase enum typedefs and the 720p timing localparams, shared with the downstream sprite stages.
REQ-020 A sub-module sync_delay (parameterised width and depth, async reset) SHALL implement REQ-013 for the 3-bit {hsync, vsync, active_draw} bundle.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release, run 1650 cycles -> hcount returns to 0, vcount=1, active_draw high for exactly 1280 of those cycles.
- Run a full frame (1,237,500 cycles) -> exactly one new_frame pulse, at h=1280/v=720; 5 vsync lines; 750 hsync pulses of 40 cycles each.
- Check the delayed outputs -> hsync_dly_out rises exactly 4 cycles after hsync_out at every occurrence; active_draw_dly_out low at h=3, high at h=4 on line 0.
- Assert rst_in at h=500/v=300 asynchronously, between edges -> all outputs 0 before the next edge; after release, h=1, v=0.
- With VTG_FRAME_COUNT_EN, run 65 frames -> frame_count_out sequence ...62,63,0,1; without the macro -> constant 0.
